// File: rtl/sdram_arb.sv
// Upstream sequencer for the SDRAM controller: arbitrates port A / port B and periodic
// auto-refresh into fixed-length ce/refresh slots, returning read data with a one-clock ack.
module sdram_arb #(
    parameter int SLOT_CLKS      = 9,
    parameter int DATA_CNT       = 6,
    parameter int REFRESH_PERIOD = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic        we_a,
    input  logic [23:0] addr_a,
    input  logic [1:0]  bs_a,
    input  logic [15:0] din_a,
    output logic        ack_a,
    output logic [15:0] dout_a,
    input  logic        req_b,
    input  logic        we_b,
    input  logic [23:0] addr_b,
    input  logic [1:0]  bs_b,
    input  logic [15:0] din_b,
    output logic        ack_b,
    output logic [15:0] dout_b,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        mem_refresh,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_bs,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);
    localparam int CW = $clog2(SLOT_CLKS);
    localparam int TW = $clog2(REFRESH_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CLKS - 1);
    localparam logic [CW-1:0] CNT_DATA = CW'(DATA_CNT);
    localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_ACCESS,
        ST_REFRESH,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic          owner_b_q, owner_b_d;
    logic          ce_q, ce_d;
    logic          we_q, we_d;
    logic          refresh_q, refresh_d;
    logic [23:0]   addr_q, addr_d;
    logic [1:0]    bs_q, bs_d;
    logic [15:0]   din_q, din_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic [15:0]   dout_a_q, dout_a_d;
    logic [15:0]   dout_b_q, dout_b_d;
    logic          tmr_wrap;

    always_comb begin
        tmr_wrap = (timer_q == TMR_LAST);
        timer_d  = tmr_wrap ? '0 : timer_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        pending_d = pending_q | tmr_wrap;
        owner_b_d = owner_b_q;
        ce_d      = ce_q;
        we_d      = we_q;
        refresh_d = refresh_q;
        addr_d    = addr_q;
        bs_d      = bs_q;
        din_d     = din_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        dout_a_d  = dout_a_q;
        dout_b_d  = dout_b_q;

        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            // GAP is the clock where ack is visible and ce/refresh are low; its closing
            // edge is an ordinary arbitration, so requesters must have dropped req by then.
            ST_IDLE, ST_GAP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (pending_q) begin
                    refresh_d = 1'b1;
                    ce_d      = 1'b0;
                    we_d      = 1'b0;
                    pending_d = tmr_wrap;
                    state_d   = ST_REFRESH;
                end else if (req_a) begin
                    ce_d      = 1'b1;
                    we_d      = we_a;
                    addr_d    = addr_a;
                    bs_d      = bs_a;
                    din_d     = din_a;
                    owner_b_d = 1'b0;
                    state_d   = ST_ACCESS;
                end else if (req_b) begin
                    ce_d      = 1'b1;
                    we_d      = we_b;
                    addr_d    = addr_b;
                    bs_d      = bs_b;
                    din_d     = din_b;
                    owner_b_d = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS, ST_REFRESH: begin
                if (state_q == ST_ACCESS && !we_q && cnt_q == CNT_DATA) begin
                    if (owner_b_q) begin
                        dout_b_d = mem_dout;
                    end else begin
                        dout_a_d = mem_dout;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    ce_d      = 1'b0;
                    refresh_d = 1'b0;
                    we_d      = 1'b0;
                    ack_a_d   = (state_q == ST_ACCESS) && !owner_b_q;
                    ack_b_d   = (state_q == ST_ACCESS) && owner_b_q;
                    state_d   = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STARTUP;
            cnt_q     <= '0;
            timer_q   <= '0;
            pending_q <= 1'b0;
            owner_b_q <= 1'b0;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            refresh_q <= 1'b0;
            addr_q    <= '0;
            bs_q      <= '0;
            din_q     <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            dout_a_q  <= '0;
            dout_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            owner_b_q <= owner_b_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            refresh_q <= refresh_d;
            addr_q    <= addr_d;
            bs_q      <= bs_d;
            din_q     <= din_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            dout_a_q  <= dout_a_d;
            dout_b_q  <= dout_b_d;
        end
    end

    assign mem_ce      = ce_q;
    assign mem_we      = we_q;
    assign mem_refresh = refresh_q;
    assign mem_addr    = addr_q;
    assign mem_bs      = bs_q;
    assign mem_din     = din_q;
    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign dout_a      = dout_a_q;
    assign dout_b      = dout_b_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: requesters push expected responses, a negedge monitor
// with a slot-timing/refresh reference model and a stand-in controller checks every slot.
module tb_sdram_arb;
    localparam int SLOT = 9;
    localparam int DCNT = 6;
    localparam int RPER = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [23:0] addr_a = '0, addr_b = '0;
    logic [1:0]  bs_a = '0, bs_b = '0;
    logic [15:0] din_a = '0, din_b = '0;
    logic        ack_a, ack_b;
    logic [15:0] dout_a, dout_b;
    logic        mem_ce, mem_we, mem_refresh;
    logic [23:0] mem_addr;
    logic [1:0]  mem_bs;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [1:0]  bs;
        logic [15:0] din;
        logic [15:0] rdata;
    } txn_t;

    txn_t expA[$];
    txn_t expB[$];

    int          edgeCnt = 0;
    logic        prevCe, prevRef, modelPending, slotActive, slotOwnerB, stableOk;
    int          ceRun, refRun, expiryEdge, riseEdge, refRiseEdge, lastAckA, lastAckB;
    logic [15:0] modelDoutA, modelDoutB;
    logic [42:0] capFields;

    sdram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .bs_a(bs_a), .din_a(din_a),
        .ack_a(ack_a), .dout_a(dout_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .bs_b(bs_b), .din_b(din_b),
        .ack_b(ack_b), .dout_b(dout_b),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_bs(mem_bs), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edgeCnt <= 0;
        else        edgeCnt <= edgeCnt + 1;
    end

    // Stand-in memory contents; 24'h001234 reads back as 16'h1234.
    function automatic logic [15:0] refData(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], 8'h00};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic handleAck(input bit portB);
        txn_t t;
        if (!slotActive) begin
            checkOutput(portB ? "ack_b_without_slot" : "ack_a_without_slot", 32'(1), 32'(0));
            return;
        end
        checkOutput("ack_port", 32'(portB), 32'(slotOwnerB));
        checkOutput("ack_latency", 32'(edgeCnt - riseEdge), 32'(SLOT));
        slotActive = 1'b0;
        if (portB) begin
            if (expB.size() > 0) begin
                t = expB.pop_front();
                if (!t.we) modelDoutB = t.rdata;
            end
            lastAckB = edgeCnt;
        end else begin
            if (expA.size() > 0) begin
                t = expA.pop_front();
                if (!t.we) modelDoutA = t.rdata;
            end
            lastAckA = edgeCnt;
        end
        checkOutput("dout_a", 32'(dout_a), 32'(modelDoutA));
        checkOutput("dout_b", 32'(dout_b), 32'(modelDoutB));
    endtask

    // Monitor and controller stand-in: refresh obligations, slot shape, grants and acks.
    always @(negedge clk) begin
        txn_t t;
        logic ownB;
        if (!rst_n) begin
            prevCe = 1'b0; prevRef = 1'b0; ceRun = 0; refRun = 0;
            modelPending = 1'b0; slotActive = 1'b0; slotOwnerB = 1'b0; stableOk = 1'b1;
            modelDoutA = '0; modelDoutB = '0; expiryEdge = 0;
            mem_dout = 16'h0;
        end else begin
            if (edgeCnt > 0 && edgeCnt % RPER == 0 && !modelPending) begin
                modelPending = 1'b1;
                expiryEdge   = edgeCnt;
            end
            if (mem_ce && mem_refresh) checkOutput("ce_with_refresh", 32'(1), 32'(0));

            if (mem_refresh && !prevRef) begin
                checkOutput("refresh_owed", 32'(modelPending), 32'(1));
                checkOutput("refresh_gap_before", 32'(prevCe), 32'(0));
                checkOutput("refresh_we_low", 32'(mem_we), 32'(0));
                if (modelPending) checkOutput("refresh_delay", 32'(edgeCnt - expiryEdge <= 11), 32'(1));
                modelPending = 1'b0;
                refRiseEdge  = edgeCnt;
            end
            if (modelPending && edgeCnt - expiryEdge > 11) begin
                checkOutput("refresh_starved", 32'(edgeCnt - expiryEdge), 32'(11));
                modelPending = 1'b0;
            end

            if (mem_ce && !prevCe) begin
                checkOutput("gap_before_slot", 32'(prevRef), 32'(0));
                checkOutput("refresh_priority", 32'(modelPending && expiryEdge < edgeCnt), 32'(0));
                checkOutput("grant_has_request", 32'(req_a || req_b), 32'(1));
                ownB = !req_a;
                if ((ownB ? expB.size() : expA.size()) == 0) begin
                    checkOutput("grant_expected", 32'(0), 32'(1));
                end else begin
                    if (ownB) t = expB[0];
                    else      t = expA[0];
                    checkOutput("grant_we", 32'(mem_we), 32'(t.we));
                    checkOutput("grant_addr", 32'(mem_addr), 32'(t.addr));
                    checkOutput("grant_bs", 32'(mem_bs), 32'(t.bs));
                    checkOutput("grant_din", 32'(mem_din), 32'(t.din));
                end
                slotActive = 1'b1;
                slotOwnerB = ownB;
                riseEdge   = edgeCnt;
                capFields  = {mem_we, mem_addr, mem_bs, mem_din};
                stableOk   = 1'b1;
            end else if (mem_ce) begin
                if ({mem_we, mem_addr, mem_bs, mem_din} !== capFields) stableOk = 1'b0;
            end

            if (!mem_ce && prevCe) begin
                checkOutput("ce_slot_len", 32'(ceRun), 32'(SLOT));
                checkOutput("slot_stable", 32'(stableOk), 32'(1));
            end
            if (!mem_refresh && prevRef) checkOutput("refresh_slot_len", 32'(refRun), 32'(SLOT));

            if (ack_a && ack_b) checkOutput("one_ack_at_a_time", 32'(1), 32'(0));
            if (ack_a)      handleAck(1'b0);
            else if (ack_b) handleAck(1'b1);

            ceRun   = mem_ce ? ceRun + 1 : 0;
            refRun  = mem_refresh ? refRun + 1 : 0;
            prevCe  = mem_ce;
            prevRef = mem_refresh;
            // Read data is valid only in the clock where the slot counter sits at DATA_CNT.
            mem_dout = (mem_ce && ceRun == DCNT + 1) ? refData(mem_addr) : ~refData(mem_addr);
        end
    end

    // Called at negedge+1; returns at negedge+1 with req dropped after the ack.
    task automatic applyStimulus(input bit portB, input logic we, input logic [23:0] addr,
                                 input logic [1:0] bs, input logic [15:0] din);
        txn_t t;
        int   n;
        t.we = we; t.addr = addr; t.bs = bs; t.din = din; t.rdata = refData(addr);
        if (portB) begin
            expB.push_back(t);
            we_b = we; addr_b = addr; bs_b = bs; din_b = din; req_b = 1'b1;
        end else begin
            expA.push_back(t);
            we_a = we; addr_a = addr; bs_a = bs; din_a = din; req_a = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(portB ? ack_b : ack_a) && n < 300);
        checkOutput(portB ? "ack_b_arrives" : "ack_a_arrives", 32'(n < 300), 32'(1));
        #1;
        if (portB) begin
            req_b = 1'b0;
            if (n >= 300 && expB.size() > 0) void'(expB.pop_front());
        end else begin
            req_a = 1'b0;
            if (n >= 300 && expA.size() > 0) void'(expA.pop_front());
        end
    endtask

    task automatic randomTraffic(input bit portB, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #1;
            applyStimulus(portB, 1'($urandom_range(0, 1)), 24'($urandom), 2'($urandom), 16'($urandom));
        end
    endtask

    function automatic logic [31:0] outVec();
        return 32'({ack_a, ack_b, mem_ce, mem_we, mem_refresh, |mem_addr, |mem_bs, |mem_din,
                    |dout_a, |dout_b});
    endfunction

    initial begin
        int   n;
        txn_t t;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs", outVec(), 32'(0));
        rst_n = 1'b1;

        for (int i = 0; i < SLOT; i++) begin
            @(negedge clk);
            checkOutput("startup_quiet", outVec(), 32'(0));
        end
        n = 0;
        while (!mem_refresh && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_refresh_edge", 32'(edgeCnt), 32'(RPER + 1));
        repeat (12) @(negedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, 24'h00C000, 2'b01, 16'hBEEF);
        @(negedge clk); #1;
        applyStimulus(1'b0, 1'b0, 24'h001234, 2'b11, 16'h0000);
        checkOutput("read_a_1234", 32'(dout_a), 32'h1234);
        checkOutput("dout_b_untouched", 32'(dout_b), 32'(0));

        @(negedge clk); #1;
        fork
            applyStimulus(1'b0, 1'b0, 24'h012345, 2'b11, 16'h1111);
            applyStimulus(1'b1, 1'b0, 24'h0A5A5A, 2'b10, 16'h2222);
        join
        checkOutput("a_then_b_spacing", 32'(lastAckB - lastAckA), 32'(SLOT + 1));

        while (edgeCnt < 2 * RPER - 6) @(negedge clk);
        #1;
        fork
            applyStimulus(1'b0, 1'b1, 24'h00F00D, 2'b11, 16'hCAFE);
            applyStimulus(1'b1, 1'b0, 24'h3C0FFE, 2'b01, 16'h3333);
        join
        checkOutput("refresh_after_a", 32'(refRiseEdge - lastAckA), 32'(1));
        checkOutput("b_after_refresh", 32'(lastAckB - refRiseEdge), 32'(2 * SLOT + 1));

        fork
            randomTraffic(1'b0, 30);
            randomTraffic(1'b1, 30);
        join

        @(negedge clk); #1;
        t.we = 1'b0; t.addr = 24'h00ABCD; t.bs = 2'b11; t.din = 16'h0; t.rdata = refData(24'h00ABCD);
        expA.push_back(t);
        we_a = 1'b0; addr_a = t.addr; bs_a = t.bs; din_a = t.din; req_a = 1'b1;
        n = 0;
        while (!mem_ce && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset_test_grant", 32'(mem_ce), 32'(1));
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_clears", outVec(), 32'(0));
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!ack_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reissued_ack", 32'(ack_a), 32'(1));
        checkOutput("regrant_edge", 32'(riseEdge), 32'(SLOT + 1));
        #1;
        req_a = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("scoreboard_drained", 32'(expA.size() + expB.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
